// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: evaluates CMP flags, pulses a PC redirect and holds a
// timed flush of IF/ID. Optional accept/taken counters are enabled by `BRANCH_STATS_EN.
module branch_resolver #(
    parameter int n            = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         br_valid,
    output logic         br_ready,
    input  logic [1:0]   br_cond,
    input  logic         zero_falg,
    input  logic         negative_flag,
    input  logic [n-1:0] br_target,
    output logic         redirect_valid,
    output logic [n-1:0] redirect_pc,
    output logic         flush,
    output logic [15:0]  stat_total,
    output logic [15:0]  stat_taken
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        COND_BEQ = 2'b00,
        COND_BNE = 2'b01,
        COND_BLT = 2'b10,
        COND_BGT = 2'b11
    } cond_e;

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         br_ready_q, br_ready_d;
    logic         redirect_valid_q, redirect_valid_d;
    logic [n-1:0] redirect_pc_q, redirect_pc_d;
    logic         flush_q, flush_d;

    logic accept;
    logic taken;

    // A branch is only seen while the unit is ready; requests during a flush
    // belong to squashed instructions and are dropped.
    assign accept = br_valid && br_ready_q;

    always_comb begin
        case (cond_e'(br_cond))
            COND_BEQ: taken = zero_falg;
            COND_BNE: taken = !zero_falg;
            COND_BLT: taken = negative_flag;
            COND_BGT: taken = !zero_falg && !negative_flag;
            default:  taken = 1'b0;
        endcase
    end

    // NOTE: every next-state signal takes its hold value first so no path leaves it
    // unassigned; otherwise this block would infer latches.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        br_ready_d       = br_ready_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = flush_q;

        case (state_q)
            S_IDLE: begin
                if (accept && taken) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = br_target;
                    flush_d          = 1'b1;
                    br_ready_d       = 1'b0;
                    cnt_d            = CNT_LOAD;
                    state_d          = S_FLUSH;
                end
            end
            S_FLUSH: begin
                redirect_valid_d = 1'b0;
                if (cnt_q == 4'd0) begin
                    flush_d    = 1'b0;
                    br_ready_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            cnt_q            <= 4'd0;
            br_ready_q       <= 1'b1;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            br_ready_q       <= br_ready_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
        end
    end

    assign br_ready       = br_ready_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] stat_total_q, stat_total_d;
    logic [15:0] stat_taken_q, stat_taken_d;

    // Both counters wrap naturally at 16 bits.
    always_comb begin
        stat_total_d = stat_total_q;
        stat_taken_d = stat_taken_q;
        if (accept) begin
            stat_total_d = stat_total_q + 16'd1;
            if (taken) begin
                stat_taken_d = stat_taken_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_total_q <= 16'd0;
            stat_taken_q <= 16'd0;
        end else begin
            stat_total_q <= stat_total_d;
            stat_taken_q <= stat_taken_d;
        end
    end

    assign stat_total = stat_total_q;
    assign stat_taken = stat_taken_q;
`else
    assign stat_total = 16'd0;
    assign stat_taken = 16'd0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: condition table, flush timing, ignored requests,
// reset during flush and (with BRANCH_STATS_EN) 16-bit statistics wrap.
module tb_branch_resolver;

    localparam int N = 32;
    localparam int K = 2;

    logic          clk;
    logic          reset;
    logic          br_valid;
    logic          br_ready;
    logic [1:0]    br_cond;
    logic          zero_falg;
    logic          negative_flag;
    logic [N-1:0]  br_target;
    logic          redirect_valid;
    logic [N-1:0]  redirect_pc;
    logic          flush;
    logic [15:0]   stat_total;
    logic [15:0]   stat_taken;

    branch_resolver #(.n(N), .FLUSH_CYCLES(K)) dut (
        .clk            (clk),
        .reset          (reset),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .br_cond        (br_cond),
        .zero_falg      (zero_falg),
        .negative_flag  (negative_flag),
        .br_target      (br_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .stat_total     (stat_total),
        .stat_taken     (stat_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cond;
        logic        zf;
        logic        nf;
        logic [31:0] target;
        logic        taken;
    } vec_t;

    vec_t        vecs[9];
    int          n_checks;
    int          n_errors;
    int          exp_total;
    int          exp_taken;
    logic [31:0] exp_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_stats(input string name);
`ifdef BRANCH_STATS_EN
        check({name, " stat_total"}, 32'(stat_total), 32'(exp_total[15:0]));
        check({name, " stat_taken"}, 32'(stat_taken), 32'(exp_taken[15:0]));
`else
        check({name, " stat_total"}, 32'(stat_total), 32'd0);
        check({name, " stat_taken"}, 32'(stat_taken), 32'd0);
`endif
    endtask

    // Starts and ends on a falling edge; accepts exactly one branch on the rising edge between.
    task automatic issue(input string name, input logic [1:0] cond, input logic zf,
                         input logic nf, input logic [31:0] target, input logic exp_tk);
        br_valid      = 1'b1;
        br_cond       = cond;
        zero_falg     = zf;
        negative_flag = nf;
        br_target     = target;
        @(negedge clk);
        br_valid = 1'b0;
        exp_total++;
        if (exp_tk) begin
            exp_taken++;
            exp_pc = target;
        end
        check({name, " redirect_valid"}, 32'(redirect_valid), 32'(exp_tk));
        check({name, " flush"},          32'(flush),          32'(exp_tk));
        check({name, " br_ready"},       32'(br_ready),       32'(!exp_tk));
        check({name, " redirect_pc"},    redirect_pc,         exp_pc);
        check_stats(name);
        if (exp_tk) begin
            for (int i = 1; i < K; i++) begin
                @(negedge clk);
                check({name, " pulse ends"},   32'(redirect_valid), 32'd0);
                check({name, " flush held"},   32'(flush),          32'd1);
                check({name, " ready held"},   32'(br_ready),       32'd0);
            end
            @(negedge clk);
            check({name, " flush done"},  32'(flush),    32'd0);
            check({name, " ready back"},  32'(br_ready), 32'd1);
            check({name, " pc held"},     redirect_pc,   exp_pc);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset    = 1'b1;
        br_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        exp_total = 0;
        exp_taken = 0;
        exp_pc    = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_total = 0;
        exp_taken = 0;
        exp_pc = '0;
        reset = 1'b1;
        br_valid = 1'b0;
        br_cond = 2'b00;
        zero_falg = 1'b0;
        negative_flag = 1'b0;
        br_target = '0;

        //          cond   zf    nf    target        taken
        vecs[0] = '{2'b00, 1'b1, 1'b0, 32'h0000_0040, 1'b1};
        vecs[1] = '{2'b00, 1'b0, 1'b1, 32'h0000_0044, 1'b0};
        vecs[2] = '{2'b01, 1'b0, 1'b0, 32'h0000_1000, 1'b1};
        vecs[3] = '{2'b01, 1'b1, 1'b0, 32'h0000_2000, 1'b0};
        vecs[4] = '{2'b10, 1'b0, 1'b1, 32'hDEAD_BEE0, 1'b1};
        vecs[5] = '{2'b10, 1'b0, 1'b0, 32'h0000_3000, 1'b0};
        vecs[6] = '{2'b11, 1'b0, 1'b0, 32'h8000_0004, 1'b1};
        vecs[7] = '{2'b11, 1'b0, 1'b1, 32'h0000_4000, 1'b0};
        vecs[8] = '{2'b11, 1'b1, 1'b0, 32'h0000_5000, 1'b0};

        // Reset state after two cycles of reset.
        @(negedge clk);
        do_reset(2);
        check("reset br_ready",       32'(br_ready),       32'd1);
        check("reset redirect_valid", 32'(redirect_valid), 32'd0);
        check("reset redirect_pc",    redirect_pc,         32'd0);
        check("reset flush",          32'(flush),          32'd0);
        check_stats("reset");

        // Condition table.
        for (int i = 0; i < 9; i++) begin
            issue($sformatf("vec%0d", i), vecs[i].cond, vecs[i].zf, vecs[i].nf,
                  vecs[i].target, vecs[i].taken);
        end

        // Not-taken BLT followed on the very next edge by a taken BGT.
        issue("blt_nt", 2'b10, 1'b0, 1'b0, 32'h0000_0900, 1'b0);
        issue("bgt_b2b", 2'b11, 1'b0, 1'b0, 32'h0000_0A00, 1'b1);

        // A request presented during flush must be ignored entirely.
        br_valid = 1'b1; br_cond = 2'b01; zero_falg = 1'b0; negative_flag = 1'b0;
        br_target = 32'h0000_0100;
        @(negedge clk);
        exp_total++; exp_taken++; exp_pc = 32'h0000_0100;
        check("bne redirect_valid", 32'(redirect_valid), 32'd1);
        br_cond = 2'b00; zero_falg = 1'b1; br_target = 32'h0000_0080;
        @(negedge clk);
        br_valid = 1'b0;
        check("ign redirect_valid", 32'(redirect_valid), 32'd0);
        check("ign redirect_pc",    redirect_pc,         32'h0000_0100);
        check_stats("ign");
        repeat (K) @(negedge clk);
        check("ign ready back", 32'(br_ready),       32'd1);
        check("ign no pulse",   32'(redirect_valid), 32'd0);
        check("ign pc kept",    redirect_pc,         32'h0000_0100);
        check_stats("ign after");

        // Reset in the first flush cycle, with a taken branch still presented.
        br_valid = 1'b1; br_cond = 2'b00; zero_falg = 1'b1; br_target = 32'h0000_00C0;
        @(negedge clk);
        check("rst_mid flush before", 32'(flush), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid flush",          32'(flush),          32'd0);
        check("rst_mid redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst_mid br_ready",       32'(br_ready),       32'd1);
        check("rst_mid redirect_pc",    redirect_pc,         32'd0);
        exp_total = 0; exp_taken = 0; exp_pc = '0;
        check_stats("rst_mid");
        reset = 1'b0; br_valid = 1'b0;
        @(negedge clk);
        check("rst_mid ready after", 32'(br_ready), 32'd1);
        check("rst_mid flush after", 32'(flush),     32'd0);

        // Statistics wrap: 65536 consecutive not-taken accepts.
`ifdef BRANCH_STATS_EN
        br_valid = 1'b1; br_cond = 2'b00; zero_falg = 1'b0; negative_flag = 1'b0;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        check("wrap total ffff", 32'(stat_total), 32'h0000_FFFF);
        @(negedge clk);
        br_valid = 1'b0;
        check("wrap total",      32'(stat_total), 32'h0000_0000);
        check("wrap taken",      32'(stat_taken), 32'h0000_0000);
        check("wrap no redirect", 32'(redirect_valid), 32'd0);
`else
        br_valid = 1'b1; br_cond = 2'b01; zero_falg = 1'b1; negative_flag = 1'b0;
        repeat (20) @(negedge clk);
        br_valid = 1'b0;
        check("nostats total", 32'(stat_total), 32'd0);
        check("nostats taken", 32'(stat_taken), 32'd0);
        check("nostats ready", 32'(br_ready),   32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
